// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch queue and the decode stage.
// fetch_entry_t is one buffered fetch result: {instr, pc, pcplus4}.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_ADDR_W-1:0] pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode, cleared by redirect flush.
// Latency: one cycle from push to head; no combinational in-to-out bypass.
// Backpressure: in_ready = not-full from registered count only; a pop never frees a slot in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FETCH_ADDR_W,
    parameter int DEPTH         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [ADDRESS_WIDTH-1:0]   in_instr,
    input  logic [ADDRESS_WIDTH-1:0]   in_pc,
    input  logic [ADDRESS_WIDTH-1:0]   in_pcplus4,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [ADDRESS_WIDTH-1:0]   out_instr,
    output logic [ADDRESS_WIDTH-1:0]   out_pc,
    output logic [ADDRESS_WIDTH-1:0]   out_pcplus4,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Same layout as fetch_entry_t, widened to follow ADDRESS_WIDTH.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] instr;
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [ADDRESS_WIDTH-1:0] pcplus4;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push;
    logic               pop;
    logic               clear;

    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign clear     = rst || flush;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: stale slots are never visible once count is zero.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= '{instr: in_instr, pc: in_pc, pcplus4: in_pcplus4};
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        out_instr   = ADDRESS_WIDTH'(NOP_INSTR);
        out_pc      = '0;
        out_pcplus4 = '0;
        if (out_valid) begin
            out_instr   = head.instr;
            out_pc      = head.pc;
            out_pcplus4 = head.pcplus4;
        end
    end

endmodule
